multiplexor_n_a_1_arbitrado: RTL and testbench
==============================================

# multiplexor_n_a_1_arbitrado

Parametrised N-to-1, W-bit registered multiplexer with per-channel valid/ready handshakes and two selection modes: fixed (external `Selector`) or round-robin arbitration. It is the sequential successor of the combinational 2-to-1 multiplexer and sits between several producer channels and a single downstream consumer. Output is registered, with one-cycle latency and full throughput.

## Interface
Parameters:
- `ANCHO`, 8: data width per channel, ≥1.
- `CANALES`, 4: channel count, ≥2.
- `ANCHO_SEL`, `$clog2(CANALES)`: selector width, derived, not overridden.

Ports:
- `Reloj`  in  1  clock; all logic on rising edge.
- `Reinicio`  in  1  reset; synchronous, active-high.
- `Entradas`  in  CANALES*ANCHO  channel i data at bits [i*ANCHO +: ANCHO].
- `Validos`  in  CANALES  channel i offers data.
- `Listos`  out  CANALES  channel i transfer accepted this cycle.
- `Modo`  in  1  0 = MODO_FIJO (use `Selector`), 1 = MODO_ROTATIVO.
- `Selector`  in  ANCHO_SEL  channel index in MODO_FIJO.
- `Salida`  out  ANCHO  registered data.
- `SalidaValida`  out  1  `Salida` holds a valid word.
- `SalidaLista`  in  1  consumer accepts the word.
- `CanalActual`  out  ANCHO_SEL  source channel of the word in `Salida`.

## Operation
- Two-state FSM on the output register: VACIO (`SalidaValida`=0), LLENO (`SalidaValida`=1).
- `puede_cargar` = VACIO, or (LLENO and `SalidaLista`).
- Grant, combinational:
  - MODO_FIJO: channel `Selector` if `Selector` < CANALES and `Validos[Selector]`. Out-of-range `Selector` → no grant (DEFECTO behaviour).
  - MODO_ROTATIVO: first channel with `Validos` set, searching from `puntero` upward, wrapping CANALES-1 → 0.
- `Listos[i]` = `puede_cargar` and grant == i. At most one bit set per cycle.
- On a transfer: `Salida` ← granted channel data; `CanalActual` ← i; state LLENO.
- In MODO_ROTATIVO, each transfer sets `puntero` ← i+1 mod CANALES. In MODO_FIJO, `puntero` holds.
- LLENO with `SalidaLista` and no grant: state → VACIO. `Salida` ← DEFECTO (0). `CanalActual` holds.
- LLENO without `SalidaLista`: `Salida` and `CanalActual` hold; all `Listos` = 0.
- A `Modo` change applies to the grant in the same cycle. `puntero` keeps its value across mode changes.
- A producer may drop `Validos` without a transfer; the block makes no stability assumption on inputs.

## Timing
- Reset, effective on the next edge: `Salida`=0, `SalidaValida`=0, `CanalActual`=0, `puntero`=0, state VACIO. `Listos` = 0 during reset.
- Reset mid-transfer discards the held word, and no `Listos` is asserted in that cycle.
- Latency: data accepted at edge k appears on `Salida` after edge k.
- Throughput: one word per cycle while `SalidaLista`=1 continuously (simultaneous drain and load).
- `Listos` depends combinationally on `Validos`, `Modo`, `Selector`, `SalidaLista` and registered state. It never depends on `Entradas`.

## Structure
- Package `multiplexor_pkg`:
  - `DEFECTO`
  - `MODO_FIJO` / `MODO_ROTATIVO`
  - state encoding `VACIO` / `LLENO`
- Sub-module `arbitro_rotativo` (parameter CANALES):
  - inputs: request vector, `puntero`
  - outputs: one-hot grant, encoded index, `hay_concesion`
  - pure combinational, reusable.
- Top level holds the FSM, `puntero`, data register and mode mux.

## Test plan
- Reset with all `Validos`=1 → `Listos`=0, `Salida`=0, `SalidaValida`=0. The first edge after reset release loads channel 0 (MODO_ROTATIVO, `puntero`=0).
- MODO_ROTATIVO, CANALES=4, all valid, `SalidaLista`=1 → `CanalActual` sequence 0,1,2,3,0 on consecutive cycles; one `Listos` bit per cycle.
- MODO_FIJO, `Selector`=2, `Entradas` ch2=8'hA5, `Validos`=4'b0100 → `Salida`=8'hA5, `CanalActual`=2 one cycle later. With `Selector`=3 and `Validos`=4'b0100 → no grant; `SalidaValida` falls after drain and `Salida`=0.
- Backpressure: LLENO, `SalidaLista`=0 for 3 cycles with `Validos`=4'b1111 → `Salida` stable, `Listos`=0. Then `SalidaLista`=1 → drain and reload in the same cycle.
- CANALES=3 (non-power-of-2), `puntero`=2, `Validos`=3'b011 → grant channel 0 (wrap), then 1. `Selector`=3 → no grant.
- Mode switch 1→0 mid-stream, then 0→1 → round-robin resumes from the preserved `puntero`.

Source files
------------

// File: rtl/multiplexor_pkg.sv
// Shared constants and state encoding for the arbitrated N-to-1 registered multiplexer.
package multiplexor_pkg;

    localparam int   DEFECTO       = 0;
    localparam logic MODO_FIJO     = 1'b0;
    localparam logic MODO_ROTATIVO = 1'b1;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

endpackage

// File: rtl/arbitro_rotativo.sv
// Combinational round-robin arbiter: first request found from puntero upward, wrapping
// at CANALES-1 (also correct for non-power-of-2 channel counts).
module arbitro_rotativo
    import multiplexor_pkg::*;
#(
    parameter int   CANALES   = 4,
    localparam int  ANCHO_SEL = $clog2(CANALES)
) (
    input  logic [CANALES-1:0]   peticiones,
    input  logic [ANCHO_SEL-1:0] puntero,
    output logic [CANALES-1:0]   concesion,
    output logic [ANCHO_SEL-1:0] indice,
    output logic                 hay_concesion
);

    logic [ANCHO_SEL-1:0] candidato;

    always_comb begin
        concesion     = '0;
        indice        = '0;
        hay_concesion = 1'b0;
        candidato     = '0;
        for (int k = 0; k < CANALES; k++) begin
            candidato = ANCHO_SEL'((int'(puntero) + k) % CANALES);
            if (!hay_concesion && peticiones[candidato]) begin
                concesion[candidato] = 1'b1;
                indice               = candidato;
                hay_concesion        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplexor_n_a_1_arbitrado.sv
// N-to-1 registered multiplexer with valid/ready per channel, fixed or round-robin selection.
// state | meaning
// VACIO | output register empty, SalidaValida = 0
// LLENO | output register holds a word, SalidaValida = 1
module multiplexor_n_a_1_arbitrado
    import multiplexor_pkg::*;
#(
    parameter int   ANCHO     = 8,
    parameter int   CANALES   = 4,
    localparam int  ANCHO_SEL = $clog2(CANALES)
) (
    input  logic                       Reloj,
    input  logic                       Reinicio,
    input  logic [CANALES*ANCHO-1:0]   Entradas,
    input  logic [CANALES-1:0]         Validos,
    output logic [CANALES-1:0]         Listos,
    input  logic                       Modo,
    input  logic [ANCHO_SEL-1:0]       Selector,
    output logic [ANCHO-1:0]           Salida,
    output logic                       SalidaValida,
    input  logic                       SalidaLista,
    output logic [ANCHO_SEL-1:0]       CanalActual
);

    estado_t              estado;
    logic [ANCHO_SEL-1:0] puntero;
    logic [CANALES-1:0]   conc_rot;
    logic [CANALES-1:0]   conc_fija;
    logic [CANALES-1:0]   concesion;
    logic [ANCHO_SEL-1:0] ind_rot;
    logic [ANCHO_SEL-1:0] indice;
    logic                 hay_rot;
    logic                 hay_concesion;
    logic                 puede_cargar;
    logic [ANCHO-1:0]     dato_sel;

    arbitro_rotativo #(.CANALES(CANALES)) u_arbitro (
        .peticiones    (Validos),
        .puntero       (puntero),
        .concesion     (conc_rot),
        .indice        (ind_rot),
        .hay_concesion (hay_rot)
    );

    // An out-of-range Selector matches no channel, so it yields no grant.
    always_comb begin
        conc_fija = '0;
        for (int i = 0; i < CANALES; i++) begin
            conc_fija[i] = Validos[i] && (Selector == ANCHO_SEL'(i));
        end
    end

    assign concesion     = (Modo == MODO_ROTATIVO) ? conc_rot : conc_fija;
    assign indice        = (Modo == MODO_ROTATIVO) ? ind_rot : Selector;
    assign hay_concesion = (Modo == MODO_ROTATIVO) ? hay_rot : |conc_fija;
    assign puede_cargar  = (estado == VACIO) || SalidaLista;
    assign Listos        = (puede_cargar && !Reinicio) ? concesion : '0;
    assign SalidaValida  = (estado == LLENO);

    always_comb begin
        dato_sel = '0;
        for (int i = 0; i < CANALES; i++) begin
            if (concesion[i]) begin
                dato_sel = Entradas[i*ANCHO +: ANCHO];
            end
        end
    end

    always_ff @(posedge Reloj) begin
        if (Reinicio) begin
            estado      <= VACIO;
            Salida      <= ANCHO'(DEFECTO);
            CanalActual <= '0;
            puntero     <= '0;
        end else if (puede_cargar && hay_concesion) begin
            estado      <= LLENO;
            Salida      <= dato_sel;
            CanalActual <= indice;
            if (Modo == MODO_ROTATIVO) begin
                puntero <= ANCHO_SEL'((int'(indice) + 1) % CANALES);
            end
        end else if ((estado == LLENO) && SalidaLista) begin
            estado <= VACIO;
            Salida <= ANCHO'(DEFECTO);
        end
    end

endmodule

// File: tb/tb_multiplexor_n_a_1_arbitrado.sv
// Bench for the arbitrated multiplexer: a 4-channel and a 3-channel instance compared
// cycle by cycle against a behavioural transfer model.
module tb_multiplexor_n_a_1_arbitrado;

    typedef struct {
        int lleno;
        int dato;
        int canal;
        int ptr;
    } modelo_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] d4_ent;
    logic [3:0]  d4_val;
    logic [3:0]  d4_lis;
    logic        d4_modo;
    logic [1:0]  d4_sel;
    logic [7:0]  d4_sal;
    logic        d4_sv;
    logic        d4_sl;
    logic [1:0]  d4_canal;

    logic [23:0] d3_ent;
    logic [2:0]  d3_val;
    logic [2:0]  d3_lis;
    logic        d3_modo;
    logic [1:0]  d3_sel;
    logic [7:0]  d3_sal;
    logic        d3_sv;
    logic        d3_sl;
    logic [1:0]  d3_canal;

    int n_cmp = 0;
    int n_err = 0;
    modelo_t m4, m3;

    multiplexor_n_a_1_arbitrado #(.ANCHO(8), .CANALES(4)) dut4 (
        .Reloj(clk), .Reinicio(rst), .Entradas(d4_ent), .Validos(d4_val), .Listos(d4_lis),
        .Modo(d4_modo), .Selector(d4_sel), .Salida(d4_sal), .SalidaValida(d4_sv),
        .SalidaLista(d4_sl), .CanalActual(d4_canal)
    );

    multiplexor_n_a_1_arbitrado #(.ANCHO(8), .CANALES(3)) dut3 (
        .Reloj(clk), .Reinicio(rst), .Entradas(d3_ent), .Validos(d3_val), .Listos(d3_lis),
        .Modo(d3_modo), .Selector(d3_sel), .Salida(d3_sal), .SalidaValida(d3_sv),
        .SalidaLista(d3_sl), .CanalActual(d3_canal)
    );

    // Which channel wins this cycle, or -1 for none.
    function automatic int f_grant(int n, logic [3:0] val, logic modo, int sel, int ptr);
        if (!modo) begin
            if (sel < n && val[sel]) return sel;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (val[c]) return c;
        end
        return -1;
    endfunction

    function automatic int f_listos(modelo_t m, int n, logic [3:0] val, logic modo, int sel,
                                    logic lista, logic r);
        int g;
        g = f_grant(n, val, modo, sel, m.ptr);
        if (r || (m.lleno != 0 && !lista) || g < 0) return 0;
        return 1 << g;
    endfunction

    function automatic modelo_t f_next(modelo_t m, int n, logic [3:0] val, logic modo, int sel,
                                       logic lista, logic [31:0] ent, logic r);
        modelo_t s;
        int g;
        s = m;
        g = f_grant(n, val, modo, sel, m.ptr);
        if (r) begin
            s = '{default: 0};
        end else if ((m.lleno == 0 || lista) && g >= 0) begin
            s.lleno = 1;
            s.dato  = int'((ent >> (g * 8)) & 32'hFF);
            s.canal = g;
            if (modo) s.ptr = (g + 1) % n;
        end else if (m.lleno != 0 && lista) begin
            s.lleno = 0;
            s.dato  = 0;
        end
        return s;
    endfunction

    task automatic ciclo4(input logic [31:0] ent, input logic [3:0] val, input logic modo,
                          input logic [1:0] sel, input logic lista, input logic r,
                          output logic [3:0] lis);
        @(negedge clk);
        d4_ent = ent; d4_val = val; d4_modo = modo; d4_sel = sel; d4_sl = lista; rst = r;
        #1;
        lis = d4_lis;
        @(posedge clk);
        #1;
    endtask

    task automatic ciclo3(input logic [31:0] ent, input logic [3:0] val, input logic modo,
                          input logic [1:0] sel, input logic lista, input logic r,
                          output logic [2:0] lis);
        @(negedge clk);
        d3_ent = ent[23:0]; d3_val = val[2:0]; d3_modo = modo; d3_sel = sel; d3_sl = lista; rst = r;
        #1;
        lis = d3_lis;
        @(posedge clk);
        #1;
    endtask

    task automatic reposo4();
        d4_val = '0; d4_sl = 1'b0;
    endtask

    task automatic reposo3();
        d3_val = '0; d3_sl = 1'b0;
    endtask

    task automatic aplicar_reset();
        logic [3:0] lis;
        ciclo4(32'h0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b1, lis);
        m4 = '{default: 0};
        m3 = '{default: 0};
    endtask

    task automatic test_reset();
        logic [3:0]  lis;
        logic [31:0] e;
        reposo3();
        for (int c = 0; c < 2; c++) begin
            ciclo4($urandom, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1, lis);
            n_cmp++; if (lis !== 4'h0) begin n_err++; $display("FAIL reset_listos obs=%b exp=0000", lis); end
            n_cmp++; if (d4_sal !== 8'h00) begin n_err++; $display("FAIL reset_salida obs=%h exp=00", d4_sal); end
            n_cmp++; if (d4_sv !== 1'b0) begin n_err++; $display("FAIL reset_valida obs=%b exp=0", d4_sv); end
            n_cmp++; if (d4_canal !== 2'd0) begin n_err++; $display("FAIL reset_canal obs=%0d exp=0", d4_canal); end
        end
        n_cmp++; if (d3_sv !== 1'b0) begin n_err++; $display("FAIL reset_valida3 obs=%b exp=0", d3_sv); end
        m4 = '{default: 0};
        m3 = '{default: 0};
        e = $urandom;
        ciclo4(e, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b1, e, 1'b0);
        n_cmp++; if (lis !== 4'b0001) begin n_err++; $display("FAIL reset_primer_listos obs=%b exp=0001", lis); end
        n_cmp++; if (d4_sal !== e[7:0]) begin n_err++; $display("FAIL reset_primer_dato obs=%h exp=%h", d4_sal, e[7:0]); end
        n_cmp++; if (d4_sv !== 1'b1) begin n_err++; $display("FAIL reset_primer_valida obs=%b exp=1", d4_sv); end
        // Reset while a word is held must drop it without handshaking anyone.
        ciclo4($urandom, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1, lis);
        m4 = '{default: 0};
        m3 = '{default: 0};
        n_cmp++; if (lis !== 4'h0) begin n_err++; $display("FAIL reset_medio_listos obs=%b exp=0000", lis); end
        n_cmp++; if (d4_sv !== 1'b0) begin n_err++; $display("FAIL reset_medio_valida obs=%b exp=0", d4_sv); end
        n_cmp++; if (d4_sal !== 8'h00) begin n_err++; $display("FAIL reset_medio_salida obs=%h exp=00", d4_sal); end
    endtask

    task automatic test_rotativo();
        logic [3:0]  lis;
        logic [31:0] e;
        logic [3:0]  el;
        aplicar_reset();
        for (int k = 0; k < 5; k++) begin
            e = $urandom;
            el = 4'(1 << (k % 4));
            ciclo4(e, 4'hF, 1'b1, 2'($urandom), 1'b1, 1'b0, lis);
            m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b1, e, 1'b0);
            n_cmp++; if (lis !== el) begin n_err++; $display("FAIL rot_listos k=%0d obs=%b exp=%b", k, lis, el); end
            n_cmp++; if (d4_canal !== 2'(k % 4)) begin n_err++; $display("FAIL rot_canal k=%0d obs=%0d exp=%0d", k, d4_canal, k % 4); end
            n_cmp++; if (d4_sal !== e[8*(k%4) +: 8]) begin n_err++; $display("FAIL rot_dato k=%0d obs=%h exp=%h", k, d4_sal, e[8*(k%4) +: 8]); end
        end
    endtask

    task automatic test_fijo();
        logic [3:0]  lis;
        logic [31:0] e;
        e = $urandom;
        e[23:16] = 8'hA5;
        ciclo4(e, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, lis);
        m4 = f_next(m4, 4, 4'b0100, 1'b0, 2, 1'b1, e, 1'b0);
        n_cmp++; if (lis !== 4'b0100) begin n_err++; $display("FAIL fijo_listos obs=%b exp=0100", lis); end
        n_cmp++; if (d4_sal !== 8'hA5) begin n_err++; $display("FAIL fijo_dato obs=%h exp=a5", d4_sal); end
        n_cmp++; if (d4_canal !== 2'd2) begin n_err++; $display("FAIL fijo_canal obs=%0d exp=2", d4_canal); end
        ciclo4(e, 4'b0100, 1'b0, 2'd3, 1'b1, 1'b0, lis);
        m4 = f_next(m4, 4, 4'b0100, 1'b0, 3, 1'b1, e, 1'b0);
        n_cmp++; if (lis !== 4'b0000) begin n_err++; $display("FAIL fijo_sin_conc_listos obs=%b exp=0000", lis); end
        n_cmp++; if (d4_sv !== 1'b0) begin n_err++; $display("FAIL fijo_vaciado obs=%b exp=0", d4_sv); end
        n_cmp++; if (d4_sal !== 8'h00) begin n_err++; $display("FAIL fijo_defecto obs=%h exp=00", d4_sal); end
        n_cmp++; if (d4_canal !== 2'd2) begin n_err++; $display("FAIL fijo_canal_mantiene obs=%0d exp=2", d4_canal); end
    endtask

    task automatic test_contrapresion();
        logic [3:0]  lis;
        logic [3:0]  el;
        logic [31:0] e;
        int          guardado;
        e = $urandom;
        ciclo4(e, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b1, e, 1'b0);
        guardado = m4.dato;
        for (int c = 0; c < 3; c++) begin
            e = $urandom;
            ciclo4(e, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, lis);
            m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b0, e, 1'b0);
            n_cmp++; if (lis !== 4'h0) begin n_err++; $display("FAIL bp_listos c=%0d obs=%b exp=0000", c, lis); end
            n_cmp++; if (d4_sal !== 8'(guardado)) begin n_err++; $display("FAIL bp_estable c=%0d obs=%h exp=%h", c, d4_sal, 8'(guardado)); end
            n_cmp++; if (d4_sv !== 1'b1) begin n_err++; $display("FAIL bp_valida c=%0d obs=%b exp=1", c, d4_sv); end
        end
        e = $urandom;
        el = 4'(f_listos(m4, 4, 4'hF, 1'b1, 0, 1'b1, 1'b0));
        ciclo4(e, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b1, e, 1'b0);
        n_cmp++; if (lis !== el || !$onehot(lis)) begin n_err++; $display("FAIL bp_recarga_listos obs=%b exp=%b", lis, el); end
        n_cmp++; if (d4_sal !== 8'(m4.dato)) begin n_err++; $display("FAIL bp_recarga_dato obs=%h exp=%h", d4_sal, 8'(m4.dato)); end
        n_cmp++; if (d4_sv !== 1'b1) begin n_err++; $display("FAIL bp_recarga_valida obs=%b exp=1", d4_sv); end
    endtask

    task automatic test_tres_canales();
        logic [2:0]  lis;
        logic [31:0] e;
        aplicar_reset();
        reposo4();
        ciclo3($urandom, 4'b0010, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        n_cmp++; if (lis !== 3'b010) begin n_err++; $display("FAIL t3_prep_listos obs=%b exp=010", lis); end
        e = $urandom;
        ciclo3(e, 4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        n_cmp++; if (lis !== 3'b001) begin n_err++; $display("FAIL t3_vuelta_listos obs=%b exp=001", lis); end
        n_cmp++; if (d3_canal !== 2'd0) begin n_err++; $display("FAIL t3_vuelta_canal obs=%0d exp=0", d3_canal); end
        n_cmp++; if (d3_sal !== e[7:0]) begin n_err++; $display("FAIL t3_vuelta_dato obs=%h exp=%h", d3_sal, e[7:0]); end
        e = $urandom;
        ciclo3(e, 4'b0011, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        n_cmp++; if (lis !== 3'b010) begin n_err++; $display("FAIL t3_sig_listos obs=%b exp=010", lis); end
        n_cmp++; if (d3_sal !== e[15:8]) begin n_err++; $display("FAIL t3_sig_dato obs=%h exp=%h", d3_sal, e[15:8]); end
        ciclo3($urandom, 4'b0111, 1'b0, 2'd3, 1'b1, 1'b0, lis);
        n_cmp++; if (lis !== 3'b000) begin n_err++; $display("FAIL t3_sel_fuera_listos obs=%b exp=000", lis); end
        n_cmp++; if (d3_sv !== 1'b0 || d3_sal !== 8'h00) begin n_err++; $display("FAIL t3_sel_fuera_vaciado obs=%b/%h exp=0/00", d3_sv, d3_sal); end
        m3 = '{lleno: 0, dato: 0, canal: 1, ptr: 2};
        reposo3();
    endtask

    task automatic test_cambio_modo();
        logic [3:0]  lis;
        logic [3:0]  el;
        logic [31:0] e;
        logic [3:0]  v;
        logic [1:0]  s;
        aplicar_reset();
        for (int c = 0; c < 2; c++) begin
            e = $urandom;
            ciclo4(e, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0, lis);
            m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b1, e, 1'b0);
        end
        for (int c = 0; c < 3; c++) begin
            e = $urandom; v = 4'($urandom); s = 2'($urandom);
            el = 4'(f_listos(m4, 4, v, 1'b0, int'(s), 1'b1, 1'b0));
            ciclo4(e, v, 1'b0, s, 1'b1, 1'b0, lis);
            m4 = f_next(m4, 4, v, 1'b0, int'(s), 1'b1, e, 1'b0);
            n_cmp++; if (lis !== el) begin n_err++; $display("FAIL modo_fijo_listos c=%0d obs=%b exp=%b", c, lis, el); end
        end
        e = $urandom;
        ciclo4(e, 4'hF, 1'b1, 2'd0, 1'b1, 1'b0, lis);
        m4 = f_next(m4, 4, 4'hF, 1'b1, 0, 1'b1, e, 1'b0);
        n_cmp++; if (lis !== 4'b0100) begin n_err++; $display("FAIL modo_reanuda_listos obs=%b exp=0100", lis); end
        n_cmp++; if (d4_canal !== 2'd2) begin n_err++; $display("FAIL modo_reanuda_canal obs=%0d exp=2", d4_canal); end
    endtask

    task automatic test_aleatorio();
        logic [3:0]  lis4;
        logic [2:0]  lis3;
        logic [3:0]  el;
        logic [31:0] e;
        logic [3:0]  v;
        logic [1:0]  s;
        logic        md, ls, r;
        reposo3();
        for (int c = 0; c < 400; c++) begin
            e = $urandom; v = 4'($urandom); s = 2'($urandom); md = 1'($urandom);
            ls = ($urandom_range(3) != 0); r = ($urandom_range(49) == 0);
            el = 4'(f_listos(m4, 4, v, md, int'(s), ls, r));
            ciclo4(e, v, md, s, ls, r, lis4);
            m4 = f_next(m4, 4, v, md, int'(s), ls, e, r);
            if (r) m3 = '{default: 0};
            n_cmp++; if (lis4 !== el) begin n_err++; $display("FAIL alea4_listos c=%0d obs=%b exp=%b", c, lis4, el); end
            n_cmp++; if (d4_sv !== (m4.lleno != 0)) begin n_err++; $display("FAIL alea4_valida c=%0d obs=%b exp=%0d", c, d4_sv, m4.lleno); end
            n_cmp++; if (d4_sal !== 8'(m4.dato)) begin n_err++; $display("FAIL alea4_dato c=%0d obs=%h exp=%h", c, d4_sal, 8'(m4.dato)); end
            n_cmp++; if (d4_canal !== 2'(m4.canal)) begin n_err++; $display("FAIL alea4_canal c=%0d obs=%0d exp=%0d", c, d4_canal, m4.canal); end
        end
        reposo4();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            e = $urandom; v = 4'($urandom) & 4'b0111; s = 2'($urandom); md = 1'($urandom);
            ls = ($urandom_range(3) != 0);
            el = 4'(f_listos(m3, 3, v, md, int'(s), ls, 1'b0));
            ciclo3(e, v, md, s, ls, 1'b0, lis3);
            m3 = f_next(m3, 3, v, md, int'(s), ls, e, 1'b0);
            n_cmp++; if (lis3 !== el[2:0]) begin n_err++; $display("FAIL alea3_listos c=%0d obs=%b exp=%b", c, lis3, el[2:0]); end
            n_cmp++; if (d3_sv !== (m3.lleno != 0)) begin n_err++; $display("FAIL alea3_valida c=%0d obs=%b exp=%0d", c, d3_sv, m3.lleno); end
            n_cmp++; if (d3_sal !== 8'(m3.dato)) begin n_err++; $display("FAIL alea3_dato c=%0d obs=%h exp=%h", c, d3_sal, 8'(m3.dato)); end
            n_cmp++; if (d3_canal !== 2'(m3.canal)) begin n_err++; $display("FAIL alea3_canal c=%0d obs=%0d exp=%0d", c, d3_canal, m3.canal); end
        end
    endtask

    initial begin
        rst = 1'b1;
        d4_ent = '0; d4_val = '0; d4_modo = 1'b1; d4_sel = '0; d4_sl = 1'b0;
        d3_ent = '0; d3_val = '0; d3_modo = 1'b1; d3_sel = '0; d3_sl = 1'b0;
        m4 = '{default: 0};
        m3 = '{default: 0};
        test_reset();
        test_rotativo();
        test_fijo();
        test_contrapresion();
        test_tres_canales();
        test_cambio_modo();
        test_aleatorio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
